dual_issue_scheduler: RTL and testbench



---
 rtl/dual_issue_scheduler.sv | 103 ++++++++++
 tb/tb_dual_issue_scheduler.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/dual_issue_scheduler.sv
// Dual-issue stage controller: pipe-conflict and scoreboard hazard checks, in-order issue, even/odd steering.
// Optional ISSUE_STATS_EN adds free-running cycle/stall/dual-issue counters.
module dual_issue_scheduler #(
  parameter  int NUM_REGS = 128,
  parameter  int LAT_W    = 3,
  localparam int RA_W     = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             s0_valid,
  input  logic             s0_pipe,
  input  logic [RA_W-1:0]  s0_ra,
  input  logic [RA_W-1:0]  s0_rb,
  input  logic [RA_W-1:0]  s0_rc,
  input  logic [2:0]       s0_src_en,
  input  logic [RA_W-1:0]  s0_rt,
  input  logic             s0_wr,
  input  logic [LAT_W-1:0] s0_lat,
  input  logic             s1_valid,
  input  logic             s1_pipe,
  input  logic [RA_W-1:0]  s1_ra,
  input  logic [RA_W-1:0]  s1_rb,
  input  logic [RA_W-1:0]  s1_rc,
  input  logic [2:0]       s1_src_en,
  input  logic [RA_W-1:0]  s1_rt,
  input  logic             s1_wr,
  input  logic [LAT_W-1:0] s1_lat,
  output logic             issue0,
  output logic             issue1,
  output logic             even_sel,
  output logic             even_valid,
  output logic             odd_sel,
  output logic             odd_valid,
  output logic [1:0]       consumed,
  output logic             stall
`ifdef ISSUE_STATS_EN
  ,
  output logic [31:0]      stat_cycles,
  output logic [31:0]      stat_stall,
  output logic [31:0]      stat_dual
`endif
);

  logic [NUM_REGS-1:0][LAT_W-1:0] cnt;

  logic raw0, raw1, waw0, waw1, pair_raw, pair_waw;
  logic iss0, iss1, ld0, ld1;

  always_comb begin
    raw0 = (s0_src_en[0] && cnt[s0_ra] != '0) ||
           (s0_src_en[1] && cnt[s0_rb] != '0) ||
           (s0_src_en[2] && cnt[s0_rc] != '0);
    raw1 = (s1_src_en[0] && cnt[s1_ra] != '0) ||
           (s1_src_en[1] && cnt[s1_rb] != '0) ||
           (s1_src_en[2] && cnt[s1_rc] != '0);
    waw0 = s0_wr && s0_lat != '0 && cnt[s0_rt] >= s0_lat;
    waw1 = s1_wr && s1_lat != '0 && cnt[s1_rt] >= s1_lat;
    pair_raw = s0_wr && ((s1_src_en[0] && s1_ra == s0_rt) ||
                         (s1_src_en[1] && s1_rb == s0_rt) ||
                         (s1_src_en[2] && s1_rc == s0_rt));
    pair_waw = s0_wr && s1_wr && s1_rt == s0_rt;
    iss0 = reset && s0_valid && !flush && !raw0 && !waw0;
    iss1 = iss0 && s1_valid && !raw1 && !waw1 && (s1_pipe != s0_pipe) && !pair_raw && !pair_waw;
    ld0  = iss0 && s0_wr && s0_lat != '0;
    ld1  = iss1 && s1_wr && s1_lat != '0;
  end

  // Slot1 only issues on the opposite pipe, so the two steering targets never collide.
  assign issue0     = iss0;
  assign issue1     = iss1;
  assign even_valid = (iss0 && !s0_pipe) || (iss1 && !s1_pipe);
  assign even_sel   = iss1 && !s1_pipe;
  assign odd_valid  = (iss0 && s0_pipe) || (iss1 && s1_pipe);
  assign odd_sel    = iss1 && s1_pipe;
  assign consumed   = {1'b0, iss0} + {1'b0, iss1};
  assign stall      = reset && s0_valid && !iss0;

  // A fresh load wins over the decrement; pair-WAW guarantees at most one load per register.
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_sb
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)                          cnt[r] <= '0;
      else if (ld0 && s0_rt == RA_W'(r))   cnt[r] <= s0_lat - LAT_W'(1);
      else if (ld1 && s1_rt == RA_W'(r))   cnt[r] <= s1_lat - LAT_W'(1);
      else if (cnt[r] != '0)               cnt[r] <= cnt[r] - LAT_W'(1);
    end
  end

`ifdef ISSUE_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_cycles <= '0;
      stat_stall  <= '0;
      stat_dual   <= '0;
    end else begin
      stat_cycles <= stat_cycles + 32'd1;
      if (stall)            stat_stall <= stat_stall + 32'd1;
      if (consumed == 2'd2) stat_dual  <= stat_dual + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed bench for dual_issue_scheduler: expected issue vectors are queued at drive time and popped at the check.
module tb_dual_issue_scheduler;

  typedef struct packed {
    logic       valid;
    logic       pipe;
    logic [6:0] ra, rb, rc;
    logic [2:0] en;
    logic [6:0] rt;
    logic       wr;
    logic [2:0] lat;
  } ins_t;

  logic clk, reset, flush;
  ins_t s0, s1;
  logic issue0, issue1, even_sel, even_valid, odd_sel, odd_valid, stall;
  logic [1:0] consumed;
`ifdef ISSUE_STATS_EN
  logic [31:0] stat_cycles, stat_stall, stat_dual;
`endif

  int errors = 0;
  int checks = 0;
  logic [8:0] exp_q[$];
  string      tag_q[$];

  dual_issue_scheduler dut (
    .clk(clk), .reset(reset), .flush(flush),
    .s0_valid(s0.valid), .s0_pipe(s0.pipe), .s0_ra(s0.ra), .s0_rb(s0.rb), .s0_rc(s0.rc),
    .s0_src_en(s0.en), .s0_rt(s0.rt), .s0_wr(s0.wr), .s0_lat(s0.lat),
    .s1_valid(s1.valid), .s1_pipe(s1.pipe), .s1_ra(s1.ra), .s1_rb(s1.rb), .s1_rc(s1.rc),
    .s1_src_en(s1.en), .s1_rt(s1.rt), .s1_wr(s1.wr), .s1_lat(s1.lat),
    .issue0(issue0), .issue1(issue1), .even_sel(even_sel), .even_valid(even_valid),
    .odd_sel(odd_sel), .odd_valid(odd_valid), .consumed(consumed), .stall(stall)
`ifdef ISSUE_STATS_EN
    , .stat_cycles(stat_cycles), .stat_stall(stat_stall), .stat_dual(stat_dual)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic ins_t mk(input logic pipe, input int ra, input int rb, input int rc,
                              input logic [2:0] en, input int rt, input logic wr, input int lat);
    ins_t i;
    i.valid = 1'b1; i.pipe = pipe;
    i.ra = 7'(ra); i.rb = 7'(rb); i.rc = 7'(rc);
    i.en = en; i.rt = 7'(rt); i.wr = wr; i.lat = 3'(lat);
    return i;
  endfunction

  // Expected vector layout: {issue0, issue1, even_valid, even_sel, odd_valid, odd_sel, consumed[1:0], stall}
  localparam logic [8:0] NONE   = 9'b0_0_0_0_0_0_00_0;
  localparam logic [8:0] STALL  = 9'b0_0_0_0_0_0_00_1;
  localparam logic [8:0] ONE_EV = 9'b1_0_1_0_0_0_01_0;
  localparam logic [8:0] DUAL01 = 9'b1_1_1_0_1_1_10_0;
  localparam logic [8:0] DUAL10 = 9'b1_1_1_1_1_0_10_0;

  // Drive inputs just after a rising edge, check on the falling edge, then advance one cycle.
  task automatic step(input ins_t a, input ins_t b, input logic fl, input logic [8:0] e, input string tag);
    logic [8:0] obs, req;
    string t;
    s0 = a; s1 = b; flush = fl;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    obs = {issue0, issue1, even_valid, even_sel, odd_valid, odd_sel, consumed, stall};
    req = exp_q.pop_front();
    t   = tag_q.pop_front();
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", t, obs, req);
    end
    @(posedge clk);
    #1;
  endtask

  ins_t nop, cons;

  initial begin
    nop = '0;
    reset = 1'b0; flush = 1'b0; s0 = '0; s1 = '0;
    #1;
    for (int i = 0; i < 3; i++)
      step(mk(0, 1, 2, 0, 3'b011, 3, 1, 2), mk(1, 10, 0, 0, 3'b001, 4, 1, 6), 1'b0, NONE, "reset_hold");
    reset = 1'b1;

    // Independent even/odd pair, then same-pipe conflict
    step(mk(0, 1, 2, 0, 3'b011, 3, 1, 2), mk(1, 10, 0, 0, 3'b001, 4, 1, 6), 1'b0, DUAL01, "dual_even_odd");
    step(mk(0, 21, 0, 0, 3'b001, 20, 1, 1), mk(0, 23, 0, 0, 3'b001, 22, 1, 1), 1'b0, ONE_EV, "pipe_conflict");
    step(mk(0, 23, 0, 0, 3'b001, 22, 1, 1), nop, 1'b0, ONE_EV, "former_s1_issues");
    step(mk(1, 0, 0, 0, 3'b000, 30, 1, 1), mk(0, 0, 0, 0, 3'b000, 31, 1, 1), 1'b0, DUAL10, "dual_odd_even");

    // Latency-6 producer: consumer waits five cycles
    step(mk(0, 0, 0, 0, 3'b000, 5, 1, 6), nop, 1'b0, ONE_EV, "producer_lat6");
    cons = mk(0, 5, 0, 0, 3'b001, 40, 0, 0);
    for (int i = 0; i < 5; i++) step(cons, nop, 1'b0, STALL, "raw_lat6_stall");
    step(cons, nop, 1'b0, ONE_EV, "raw_lat6_issue");

    // Latency 1 allows back-to-back issue
    step(mk(0, 0, 0, 0, 3'b000, 6, 1, 1), nop, 1'b0, ONE_EV, "producer_lat1");
    step(mk(0, 6, 0, 0, 3'b001, 41, 1, 1), nop, 1'b0, ONE_EV, "back_to_back");

    // Intra-pair RAW (rb and rc) and WAW
    step(mk(0, 0, 0, 0, 3'b000, 7, 1, 2), mk(1, 0, 7, 0, 3'b010, 42, 1, 1), 1'b0, ONE_EV, "pair_raw_rb");
    step(mk(0, 0, 0, 0, 3'b000, 13, 1, 1), mk(1, 0, 0, 13, 3'b100, 43, 0, 0), 1'b0, ONE_EV, "pair_raw_rc");
    step(mk(0, 0, 0, 0, 3'b000, 8, 1, 1), mk(1, 0, 0, 0, 3'b000, 8, 1, 1), 1'b0, ONE_EV, "pair_waw");

    // Slot0 hazard blocks a ready slot1
    step(mk(0, 0, 0, 0, 3'b000, 11, 1, 3), nop, 1'b0, ONE_EV, "producer_lat3");
    for (int i = 0; i < 2; i++)
      step(mk(0, 11, 0, 0, 3'b001, 44, 0, 0), mk(1, 0, 0, 0, 3'b000, 12, 1, 1), 1'b0, STALL, "in_order_block");
    step(mk(0, 11, 0, 0, 3'b001, 44, 0, 0), mk(1, 0, 0, 0, 3'b000, 12, 1, 1), 1'b0, DUAL01, "in_order_release");

    // WAW: cnt[9]=4 blocks lat-2 writer until cnt drops to 1; flush still lets it count down
    step(mk(0, 0, 0, 0, 3'b000, 9, 1, 5), nop, 1'b0, ONE_EV, "producer_lat5");
    step(mk(0, 0, 0, 0, 3'b000, 9, 1, 2), nop, 1'b0, STALL, "waw_cnt4");
    step(mk(0, 0, 0, 0, 3'b000, 9, 1, 2), nop, 1'b1, STALL, "waw_flush_cnt3");
    step(mk(0, 0, 0, 0, 3'b000, 9, 1, 2), nop, 1'b0, STALL, "waw_cnt2");
    step(mk(0, 0, 0, 0, 3'b000, 9, 1, 2), nop, 1'b0, ONE_EV, "waw_issue_cnt1");
    step(mk(0, 9, 0, 0, 3'b001, 45, 0, 0), nop, 1'b0, STALL, "reload_lat2_stall");
    step(mk(0, 9, 0, 0, 3'b001, 45, 0, 0), nop, 1'b0, ONE_EV, "reload_lat2_issue");

    // Flush suppresses loads; lat 0 is untracked
    step(mk(0, 0, 0, 0, 3'b000, 14, 1, 7), mk(1, 0, 0, 0, 3'b000, 46, 1, 1), 1'b1, STALL, "flush_no_issue");
    step(mk(0, 14, 0, 0, 3'b001, 47, 0, 0), nop, 1'b0, ONE_EV, "flush_no_load");
    step(mk(0, 0, 0, 0, 3'b000, 15, 1, 0), nop, 1'b0, ONE_EV, "lat0_producer");
    step(mk(0, 15, 0, 0, 3'b001, 48, 0, 0), nop, 1'b0, ONE_EV, "lat0_untracked");

    // Mid-operation reset clears the scoreboard
    step(mk(0, 0, 0, 0, 3'b000, 16, 1, 7), nop, 1'b0, ONE_EV, "producer_lat7");
    reset = 1'b0;
    step(mk(0, 16, 0, 0, 3'b001, 49, 0, 0), mk(1, 0, 0, 0, 3'b000, 50, 1, 1), 1'b0, NONE, "mid_reset_outputs");
    reset = 1'b1;
    step(mk(0, 16, 0, 0, 3'b001, 49, 0, 0), nop, 1'b0, ONE_EV, "post_reset_issue");
    step(nop, nop, 1'b0, NONE, "idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
